ddr_cmd_decoder: RTL and testbench

DDR_CMD_DECODER -- requirements
Module: ddr_cmd_decoder

---
 rtl/ddr_cmd_decoder.sv | 195 +++++++++++++++++++
 tb/tb_ddr_cmd_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_decoder.sv
// Turns sampled DDR command pins into registered one-cycle strobes, while tracking open banks, refresh busy time and CKE power state.
// Latency: one cycle from pin sample to strobe. No backpressure: illegal commands are dropped and flagged with a one-cycle illegal pulse.
module ddr_cmd_decoder #(
  parameter int BANKS = 4,
  parameter int ROWS  = 131072,
  parameter int COLS  = 1024,
  parameter int TRFC  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cke,
  input  logic                     cs_n,
  input  logic                     act_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     we_n,
  input  logic [$clog2(BANKS)-1:0] ba,
  input  logic [$clog2(ROWS)-1:0]  addr,
  output logic                     ACT,
  output logic                     RD,
  output logic                     RDA,
  output logic                     WR,
  output logic                     WRA,
  output logic                     PR,
  output logic                     PRA,
  output logic                     REF,
  output logic                     SRF,
  output logic                     MRW,
  output logic                     MRR,
  output logic                     BST,
  output logic                     PD,
  output logic                     PDX,
  output logic [$clog2(BANKS)-1:0] bank,
  output logic [$clog2(ROWS)-1:0]  row,
  output logic [$clog2(COLS)-1:0]  column,
  output logic                     halt,
  output logic                     illegal
);

  localparam int BW  = $clog2(BANKS);
  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);
  localparam int CW  = $clog2(TRFC);
  localparam logic [CW-1:0] RFC_LOAD = CW'(TRFC - 1);

  localparam logic [1:0] ST_ACTIVE  = 2'd0;
  localparam logic [1:0] ST_PWRDN   = 2'd1;
  localparam logic [1:0] ST_SELFREF = 2'd2;

  localparam int S_ACT = 13, S_RD  = 12, S_RDA = 11, S_WR  = 10, S_WRA = 9;
  localparam int S_PR  = 8,  S_PRA = 7,  S_REF = 6,  S_SRF = 5,  S_MRW = 4;
  localparam int S_MRR = 3,  S_BST = 2,  S_PD  = 1,  S_PDX = 0;

  logic [13:0]      strb_q, strb_d, sel;
  logic             illegal_q, illegal_d;
  logic             halt_q, halt_d;
  logic [CW-1:0]    rfc_q, rfc_d;
  logic [1:0]       state_q, state_d;
  logic             cke_q;
  logic [BANKS-1:0] open_q, open_d;
  logic [BW-1:0]    bank_q, bank_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CLW-1:0]   column_q, column_d;
  logic [RW-1:0]    open_row_q [BANKS];
  logic             row_we, legal, ref_pins;
  logic [2:0]       rcw;

  assign rcw      = {ras_n, cas_n, we_n};
  assign ref_pins = !cs_n && act_n && (rcw == 3'b001);

  always_comb begin
    strb_d    = '0;
    illegal_d = 1'b0;
    state_d   = state_q;
    open_d    = open_q;
    bank_d    = bank_q;
    row_d     = row_q;
    column_d  = column_q;
    row_we    = 1'b0;
    sel       = '0;
    legal     = 1'b1;
    halt_d    = halt_q;
    rfc_d     = rfc_q;

    // The refresh count keeps running in every power state, including self-refresh.
    if (halt_q) begin
      if (rfc_q == '0) halt_d = 1'b0;
      else             rfc_d  = rfc_q - CW'(1);
    end

    if (state_q == ST_ACTIVE) begin
      if (cke_q && !cke) begin
        if (ref_pins) begin
          strb_d[S_SRF] = 1'b1;
          state_d       = ST_SELFREF;
        end else begin
          strb_d[S_PD]  = 1'b1;
          state_d       = ST_PWRDN;
        end
      end else if (cke && !cs_n) begin
        if (!act_n) begin
          sel[S_ACT] = 1'b1;
          legal      = !open_q[ba];
        end else begin
          case (rcw)
            3'b001: begin
              sel[S_REF] = 1'b1;
              legal      = ~|open_q;
            end
            3'b010: sel[addr[10] ? S_PRA : S_PR] = 1'b1;
            3'b100: begin
              sel[addr[10] ? S_WRA : S_WR] = 1'b1;
              legal = open_q[ba];
            end
            3'b101: begin
              sel[addr[10] ? S_RDA : S_RD] = 1'b1;
              legal = open_q[ba];
            end
            3'b000:  sel[S_MRW] = 1'b1;
            3'b011:  sel[S_MRR] = 1'b1;
            3'b110:  sel[S_BST] = 1'b1;
            default: sel        = '0;
          endcase
        end
        if (halt_q) legal = 1'b0;

        if (sel != '0) begin
          if (!legal) begin
            illegal_d = 1'b1;
          end else begin
            strb_d = sel;
            bank_d = ba;
            if (sel[S_ACT]) begin
              open_d[ba] = 1'b1;
              row_d      = addr;
              row_we     = 1'b1;
            end
            if (sel[S_RD] | sel[S_RDA] | sel[S_WR] | sel[S_WRA]) begin
              row_d    = open_row_q[ba];
              column_d = addr[CLW-1:0];
            end
            if (sel[S_RDA] | sel[S_WRA] | sel[S_PR]) open_d[ba] = 1'b0;
            if (sel[S_PRA]) open_d = '0;
            if (sel[S_REF]) begin
              halt_d = 1'b1;
              rfc_d  = RFC_LOAD;
            end
          end
        end
      end
    end else if (!cke_q && cke) begin
      strb_d[S_PDX] = 1'b1;
      state_d       = ST_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strb_q    <= '0;
      illegal_q <= 1'b0;
      halt_q    <= 1'b0;
      rfc_q     <= '0;
      state_q   <= ST_ACTIVE;
      cke_q     <= 1'b1;
      open_q    <= '0;
      bank_q    <= '0;
      row_q     <= '0;
      column_q  <= '0;
    end else begin
      strb_q    <= strb_d;
      illegal_q <= illegal_d;
      halt_q    <= halt_d;
      rfc_q     <= rfc_d;
      state_q   <= state_d;
      cke_q     <= cke;
      open_q    <= open_d;
      bank_q    <= bank_d;
      row_q     <= row_d;
      column_q  <= column_d;
    end
  end

  // Row contents are only meaningful while the open flag is set, so they need no reset.
  always_ff @(posedge clk) begin
    if (row_we && !rst) open_row_q[ba] <= addr;
  end

  assign {ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, MRW, MRR, BST, PD, PDX} = strb_q;
  assign bank    = bank_q;
  assign row     = row_q;
  assign column  = column_q;
  assign halt    = halt_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Bench for ddr_cmd_decoder: directed command sequences checked every cycle against a behavioural model,
// plus literal expectations at the interesting points of each scenario.
module tb_ddr_cmd_decoder;
  localparam int BANKS = 4;
  localparam int ROWS  = 131072;
  localparam int COLS  = 1024;
  localparam int TRFC  = 8;

  localparam int E_ACT = 13, E_RD  = 12, E_RDA = 11, E_WR  = 10, E_WRA = 9;
  localparam int E_PR  = 8,  E_PRA = 7,  E_REF = 6,  E_SRF = 5,  E_MRW = 4;
  localparam int E_MRR = 3,  E_BST = 2,  E_PD  = 1,  E_PDX = 0;

  logic        clk = 1'b0;
  logic        rst, cke, cs_n, act_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [16:0] addr;
  logic        ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, MRW, MRR, BST, PD, PDX;
  logic [1:0]  bank;
  logic [16:0] row;
  logic [9:0]  column;
  logic        halt, illegal;

  int checks = 0;
  int errors = 0;

  ddr_cmd_decoder #(.BANKS(BANKS), .ROWS(ROWS), .COLS(COLS), .TRFC(TRFC)) dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
    .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR), .PRA(PRA), .REF(REF),
    .SRF(SRF), .MRW(MRW), .MRR(MRR), .BST(BST), .PD(PD), .PDX(PDX),
    .bank(bank), .row(row), .column(column), .halt(halt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: open flags and rows per bank, remaining halt cycles, power mode (0 active, 1 power-down, 2 self-refresh).
  bit  m_open [BANKS];
  int  m_row  [BANKS];
  int  m_halt_left;
  int  m_pmode;
  bit  m_cke_prev;
  bit  m_valid = 1'b0;
  int  e_idx, e_bank, e_row, e_col;
  bit  e_ill, e_halt, chk_b, chk_r, chk_c;

  always @(posedge clk) begin : model
    bit busy, legal;
    int idx;
    e_idx = -1; e_ill = 1'b0; chk_b = 1'b0; chk_r = 1'b0; chk_c = 1'b0;
    if (rst) begin
      for (int i = 0; i < BANKS; i++) m_open[i] = 1'b0;
      m_halt_left = 0; m_pmode = 0; m_cke_prev = 1'b1;
      e_bank = 0; e_row = 0; e_col = 0;
      chk_b = 1'b1; chk_r = 1'b1; chk_c = 1'b1;
    end else begin
      busy = (m_halt_left > 0);
      if (m_halt_left > 0) m_halt_left--;
      if (m_pmode == 0) begin
        if (m_cke_prev && !cke) begin
          if (!cs_n && act_n && {ras_n, cas_n, we_n} == 3'b001) begin
            e_idx = E_SRF; m_pmode = 2;
          end else begin
            e_idx = E_PD; m_pmode = 1;
          end
        end else if (cke && !cs_n) begin
          idx = -1; legal = 1'b1;
          if (!act_n) begin
            idx = E_ACT; legal = !m_open[ba];
          end else begin
            case ({ras_n, cas_n, we_n})
              3'b001: begin
                idx = E_REF;
                for (int i = 0; i < BANKS; i++) if (m_open[i]) legal = 1'b0;
              end
              3'b010: idx = addr[10] ? E_PRA : E_PR;
              3'b100: begin idx = addr[10] ? E_WRA : E_WR; legal = m_open[ba]; end
              3'b101: begin idx = addr[10] ? E_RDA : E_RD; legal = m_open[ba]; end
              3'b000: idx = E_MRW;
              3'b011: idx = E_MRR;
              3'b110: idx = E_BST;
              default: idx = -1;
            endcase
          end
          if (idx >= 0) begin
            if (busy || !legal) begin
              e_ill = 1'b1;
            end else begin
              e_idx = idx;
              e_bank = ba;
              if (idx == E_ACT) begin
                m_open[ba] = 1'b1; m_row[ba] = addr;
                e_row = addr; chk_b = 1'b1; chk_r = 1'b1;
              end else if (idx == E_RD || idx == E_RDA || idx == E_WR || idx == E_WRA) begin
                e_row = m_row[ba]; e_col = addr % COLS;
                chk_b = 1'b1; chk_r = 1'b1; chk_c = 1'b1;
                if (idx == E_RDA || idx == E_WRA) m_open[ba] = 1'b0;
              end else if (idx == E_PR) begin
                m_open[ba] = 1'b0; chk_b = 1'b1;
              end else if (idx == E_PRA) begin
                for (int i = 0; i < BANKS; i++) m_open[i] = 1'b0;
              end else if (idx == E_REF) begin
                m_halt_left = TRFC;
              end
            end
          end
        end
      end else if (!m_cke_prev && cke) begin
        e_idx = E_PDX; m_pmode = 0;
      end
      m_cke_prev = cke;
    end
    e_halt  = (m_halt_left > 0);
    m_valid = 1'b1;
  end

  always @(negedge clk) begin : compare
    logic [13:0] ev;
    if (m_valid) begin
      ev = '0;
      if (e_idx >= 0) ev[e_idx] = 1'b1;
      check("strobes", {18'd0, ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, MRW, MRR, BST, PD, PDX}, {18'd0, ev});
      check("illegal", {31'd0, illegal}, {31'd0, e_ill});
      check("halt", {31'd0, halt}, {31'd0, e_halt});
      if (chk_b) check("bank", {30'd0, bank}, e_bank);
      if (chk_r) check("row", {15'd0, row}, e_row);
      if (chk_c) check("column", {22'd0, column}, e_col);
    end
  end

  task automatic drive(input logic c, input logic a, input logic [2:0] rcw_v, input int b, input int ad);
    cs_n = c; act_n = a; {ras_n, cas_n, we_n} = rcw_v;
    ba = b[1:0]; addr = ad[16:0];
    @(negedge clk);
  endtask

  task automatic des();                  drive(1'b1, 1'b1, 3'b111, 0, 0);               endtask
  task automatic nop();                  drive(1'b0, 1'b1, 3'b111, 0, 0);               endtask
  task automatic act(input int b, input int r); drive(1'b0, 1'b0, 3'b111, b, r);         endtask
  task automatic rd(input int b, input int c, input bit ap); drive(1'b0, 1'b1, 3'b101, b, c + (ap ? 1024 : 0)); endtask
  task automatic wr(input int b, input int c, input bit ap); drive(1'b0, 1'b1, 3'b100, b, c + (ap ? 1024 : 0)); endtask
  task automatic pre(input int b, input bit all); drive(1'b0, 1'b1, 3'b010, b, all ? 1024 : 0); endtask
  task automatic refr();                 drive(1'b0, 1'b1, 3'b001, 0, 0);               endtask

  initial begin
    rst = 1'b1; cke = 1'b1;
    cs_n = 1'b1; act_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1; ba = '0; addr = '0;
    @(negedge clk);
    act(0, 'h77);
    check("reset_strobe_ACT", {31'd0, ACT}, 32'd0);
    check("reset_halt", {31'd0, halt}, 32'd0);
    check("reset_bank_row", {13'd0, bank, row}, 32'd0);
    rst = 1'b0;

    rd(0, 0, 1'b0);
    check("act_in_reset_discarded", {31'd0, illegal}, 32'd1);

    act(2, 'h1234);
    check("act_strobe", {31'd0, ACT}, 32'd1);
    check("act_row", {15'd0, row}, 32'h1234);
    check("act_bank", {30'd0, bank}, 32'd2);
    rd(2, 5, 1'b0);
    check("rd_strobe", {31'd0, RD}, 32'd1);
    check("rd_row", {15'd0, row}, 32'h1234);
    check("rd_column", {22'd0, column}, 32'd5);
    nop();

    rd(1, 0, 1'b0);
    check("rd_closed_illegal", {31'd0, illegal}, 32'd1);
    check("rd_closed_no_strobe", {31'd0, RD}, 32'd0);
    des();
    act(1, 'h0abc);
    act(1, 'h0def);
    check("act_open_illegal", {31'd0, illegal}, 32'd1);
    pre(1, 1'b0);
    pre(1, 1'b0);
    check("pr_closed_legal", {31'd0, PR}, 32'd1);
    pre(2, 1'b0);
    act(0, 'h55);
    wr(0, 3, 1'b1);
    check("wra_strobe", {31'd0, WRA}, 32'd1);
    rd(0, 0, 1'b0);

    refr();
    check("ref_strobe", {31'd0, REF}, 32'd1);
    check("ref_halt", {31'd0, halt}, 32'd1);
    act(0, 1);
    check("act_in_halt_illegal", {31'd0, illegal}, 32'd1);
    repeat (6) nop();
    check("halt_last_cycle", {31'd0, halt}, 32'd1);
    act(0, 1);
    check("act_on_halt_edge_illegal", {31'd0, illegal}, 32'd1);
    check("halt_dropped", {31'd0, halt}, 32'd0);
    act(0, 'h99);
    check("act_after_halt", {31'd0, ACT}, 32'd1);
    refr();
    check("ref_open_bank_illegal", {31'd0, illegal}, 32'd1);
    drive(1'b0, 1'b1, 3'b000, 0, 0);
    drive(1'b0, 1'b1, 3'b011, 1, 0);
    drive(1'b0, 1'b1, 3'b110, 2, 0);
    nop();

    cke = 1'b0;
    des();
    check("pd_strobe", {31'd0, PD}, 32'd1);
    rd(0, 7, 1'b0);
    check("rd_in_pd_ignored", {30'd0, RD, illegal}, 32'd0);
    cke = 1'b1;
    des();
    check("pdx_strobe", {31'd0, PDX}, 32'd1);
    rd(0, 7, 1'b0);
    check("rd_after_pdx_row", {15'd0, row}, 32'h99);

    act(3, 'h3333);
    pre(0, 1'b1);
    check("pra_strobe", {31'd0, PRA}, 32'd1);
    refr();
    check("ref_after_pra", {31'd0, REF}, 32'd1);
    nop();
    nop();
    cke = 1'b0;
    refr();
    check("srf_strobe", {31'd0, SRF}, 32'd1);
    check("srf_keeps_halt", {31'd0, halt}, 32'd1);
    repeat (4) des();
    check("halt_in_selfref", {31'd0, halt}, 32'd1);
    des();
    check("halt_done_in_selfref", {31'd0, halt}, 32'd0);
    cke = 1'b1;
    des();
    check("pdx_from_selfref", {31'd0, PDX}, 32'd1);

    refr();
    nop();
    rst = 1'b1;
    des();
    check("rst_mid_refresh_halt", {31'd0, halt}, 32'd0);
    rst = 1'b0;
    act(1, 'h10);
    rst = 1'b1;
    des();
    rst = 1'b0;
    rd(1, 0, 1'b0);
    check("rd_after_rst_illegal", {31'd0, illegal}, 32'd1);
    rd(0, 0, 1'b0);
    des();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
